// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin sharing of one external shifter between two requesters
module shift_unit_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_x,
    input  logic [N-1:0] req0_y,
    input  logic [1:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_x,
    input  logic [N-1:0] req1_y,
    input  logic [1:0]   req1_op,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [N-1:0] rsp_z,
    output logic         rsp_err,
    output logic [N-1:0] shf_x,
    output logic [N-1:0] shf_y,
    output logic [1:0]   shf_op,
    input  logic [N-1:0] shf_z,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    logic last_grant, owner, err;
    logic [N-1:0] x_r, y_r, result;
    logic [1:0] op_r;
    logic idle, illegal;
    always_comb begin
        idle = state == IDLE;
        illegal = op_r == 2'b11;
        req0_ready = idle && req0_valid && (!req1_valid || last_grant);
        req1_ready = idle && req1_valid && (!req0_valid || !last_grant);
        busy = !idle;
        shf_x = idle ? '0 : x_r;
        shf_y = idle ? '0 : y_r;
        shf_op = (idle || illegal) ? 2'b00 : op_r;
        rsp0_valid = state == RESP && !owner;
        rsp1_valid = state == RESP && owner;
        rsp_z = state == RESP ? result : '0;
        rsp_err = state == RESP && err;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last_grant <= 1'b1;
            owner <= 1'b0;
            err <= 1'b0;
            x_r <= '0;
            y_r <= '0;
            op_r <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    owner <= req1_ready;
                    x_r <= req1_ready ? req1_x : req0_x;
                    y_r <= req1_ready ? req1_y : req0_y;
                    op_r <= req1_ready ? req1_op : req0_op;
                    state <= EXEC;
                end
                EXEC: begin
                    result <= illegal ? '0 : shf_z;
                    err <= illegal;
                    state <= RESP;
                end
                default: begin
                    last_grant <= owner;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter: directed and random stimulus against a cycle-count reference model
module tb_shift_unit_arbiter;
    logic clk = 0, rst = 1;
    logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [31:0] req0_x = 0, req0_y = 0, req1_x = 0, req1_y = 0;
    logic [1:0] req0_op = 0, req1_op = 0, shf_op;
    logic rsp0_valid, rsp1_valid, rsp_err, busy;
    logic [31:0] rsp_z, shf_x, shf_y, shf_z;
    int checks = 0, failures = 0;
    int cyc = 0, acc = -10;
    logic last = 1, own = 0, ex_err = 0;
    logic [31:0] ex_x = 0, ex_y = 0, ex_z = 0;
    logic [1:0] ex_op = 0;

    shift_unit_arbiter #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .shf_x(shf_x), .shf_y(shf_y), .shf_op(shf_op), .shf_z(shf_z), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] shift(input logic [31:0] x, y, input logic [1:0] op);
        case (op)
            2'd0: return x << y[4:0];
            2'd1: return x >> y[4:0];
            2'd2: return 32'($signed(x) >>> y[4:0]);
            default: return ~x;
        endcase
    endfunction

    assign shf_z = shift(shf_x, shf_y, shf_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v0, input logic [31:0] x0, y0, input logic [1:0] o0,
                        input logic v1, input logic [31:0] x1, y1, input logic [1:0] o1);
        int d;
        logic fr, g0, g1, ex;
        @(posedge clk);
        #1;
        rst = r;
        req0_valid = v0; req0_x = x0; req0_y = y0; req0_op = o0;
        req1_valid = v1; req1_x = x1; req1_y = y1; req1_op = o1;
        #1;
        d = cyc - acc;
        fr = d >= 3;
        ex = d == 1 || d == 2;
        g0 = fr && v0 && (!v1 || last);
        g1 = fr && v1 && (!v0 || !last);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("busy", busy, !fr);
        chk("rsp0_valid", rsp0_valid, d == 2 && !own);
        chk("rsp1_valid", rsp1_valid, d == 2 && own);
        chk("rsp_z", rsp_z, d == 2 ? ex_z : 0);
        chk("rsp_err", rsp_err, d == 2 && ex_err);
        chk("shf_x", shf_x, ex ? ex_x : 0);
        chk("shf_y", shf_y, ex ? ex_y : 0);
        chk("shf_op", shf_op, (ex && ex_op != 2'd3) ? ex_op : 0);
        if (r) begin
            acc = cyc - 10;
            last = 1;
        end else if (g0 || g1) begin
            acc = cyc;
            own = g1;
            last = g1;
            ex_x = g1 ? x1 : x0;
            ex_y = g1 ? y1 : y0;
            ex_op = g1 ? o1 : o0;
            ex_err = ex_op == 2'd3;
            ex_z = ex_err ? 0 : shift(ex_x, ex_y, ex_op);
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        idle(2);
        step(0, 1, 32'h1, 32'd4, 2'd0, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 12; i++) step(0, 1, 32'h8000_0000, 32'd1, 2'd2, 1, 32'h8000_0000, 32'd1, 2'd1);
        idle(1);
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd7, 2'd3);
        idle(3);
        step(0, 1, 32'hFF, 32'h23, 2'd0, 0, 0, 0, 0);
        idle(3);
        step(0, 1, 32'h1, 32'h1, 2'd0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 4; i++) step(0, 1, 32'h5, 32'h2, 2'd0, 1, 32'hF0, 32'h4, 2'd1);
        idle(3);
        step(0, 1, 32'h3, 32'h1, 2'd0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 32'h1234_5678, 32'h8, 2'd1);
        idle(3);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 40) == 0,
                 1'($urandom), $urandom, $urandom, 2'($urandom),
                 1'($urandom), $urandom, $urandom, 2'($urandom));
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Round-robin controller that shares one combinational shifter between two requesters (SLL/SRL/SRA).
- The shifter is external to this block; it receives operands from this block's shf_* outputs and returns its result on shf_z.
- Each request has a valid/ready handshake; each response is a one-cycle valid pulse with a registered result.
- Sits between the ALU issue logic and the shared shifter, so there is one shifter instance per datapath.

Parameters:
- N, 32, data width of X, Y and Z.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- req0_valid  in  1  requester 0 has a request pending.
- req0_ready  out  1  requester 0's request is accepted this cycle.
- req0_x  in  N  requester 0 operand to shift.
- req0_y  in  N  requester 0 shift amount; only [4:0] is meaningful.
- req0_op  in  2  requester 0 op: 00=SLL, 01=SRL, 10=SRA, 11=illegal.
- req1_valid, req1_ready, req1_x, req1_y, req1_op: same as requester 0, for requester 1.
- rsp0_valid  out  1  one-cycle pulse; response for requester 0.
- rsp1_valid  out  1  one-cycle pulse; response for requester 1.
- rsp_z  out  N  result, valid while either rsp*_valid is high.
- rsp_err  out  1  high with rsp*_valid when the op was illegal.
- shf_x  out  N  operand to shared shifter.
- shf_y  out  N  shift amount to shared shifter.
- shf_op  out  2  op to shared shifter.
- shf_z  in  N  combinational result from shared shifter.
- busy  out  1  high in EXEC and RESP.

Behaviour:
- Reset (rst=1 at a clock edge) puts the block in this state:
  - state=IDLE, last_grant=1, so requester 0 wins the first tie.
  - Operand, op, owner and result registers = 0.
  - All outputs = 0.
  - Reset mid-operation abandons the operation; no response is ever issued for it.
- FSM states: IDLE -> EXEC -> RESP -> IDLE. Fixed 3-cycle occupancy per operation.
- IDLE:
  - reqN_ready is combinational and equals the grant. At most one ready is high per cycle.
  - Only req0_valid: grant 0. Only req1_valid: grant 1.
  - Both valid: grant the requester that is not last_grant.
  - On a grant: latch x, y, op and owner=N; next state = EXEC.
  - No valid: stay in IDLE; shf_* = 0.
- EXEC:
  - shf_x, shf_y and shf_op are driven from the latched registers.
  - If op != 11: capture shf_z into the result register and clear err.
  - If op = 11: result = 0, err = 1, shf_op driven 00.
  - Next state = RESP. Both readys are low.
- RESP:
  - rsp{owner}_valid = 1 for exactly one cycle; rsp_z = result; rsp_err = err.
  - last_grant <= owner; next state = IDLE.
  - shf_* keep the latched values, so shf_z remains valid for observation.
- Latency and throughput:
  - Accept at cycle T gives the response pulse at T+2.
  - Next accept is possible at T+3, i.e. one operation per 3 cycles maximum.
- Requests arriving during EXEC or RESP are not accepted.
  - Requesters must hold valid and operands stable until they see ready.
  - A valid dropped before acceptance is simply not serviced; no error.
- No backpressure on responses: requesters must accept the pulse.
- Fairness: with both requesters valid continuously, grants alternate 0,1,0,1, ... starting with 0 after reset.
- rsp_z is 0 whenever both rsp*_valid are low.
- The block does no shift arithmetic itself. Y[31:5] is passed through unchanged; the shifter ignores it.

Test Plan:
- After reset, assert req0 with x=0x0000_0001, y=4, op=00:
  - req0_ready=1 in the same cycle.
  - rsp0_valid pulses 2 cycles later with rsp_z=0x0000_0010, rsp_err=0.
  - busy=1 for exactly 2 cycles.
- Hold req0 and req1 valid continuously:
  - req0: x=0x8000_0000, y=1, op=10 (SRA). req1: x=0x8000_0000, y=1, op=01 (SRL).
  - Grants alternate 0,1,0,1.
  - rsp0 gives 0xC000_0000; rsp1 gives 0x4000_0000.
  - Accepts are spaced exactly 3 cycles apart.
- req1 alone with op=11, x=0xFFFF_FFFF:
  - rsp1_valid pulses with rsp_z=0 and rsp_err=1.
  - shf_op=00 during EXEC.
- Shift-amount masking: req0 with x=0x0000_00FF, y=0x0000_0023, op=00 (SLL):
  - Shifter uses 3, so rsp_z=0x0000_07F8.
  - shf_y carries 0x0000_0023 during EXEC.
- Reset mid-op: accept req0 (x=1, y=1, op=00), then assert rst in the EXEC cycle:
  - No rsp0_valid ever appears.
  - State returns to IDLE.
  - Next tie between req0 and req1 grants requester 0.
- Late request: req1 asserts valid during EXEC of a requester-0 operation:
  - req1_ready stays low through RESP.
  - req1 is granted in the following IDLE cycle.
